step_counter: RTL and testbench

Parametrised stride counter: the generalised successor to the fixed 8-bit odd counter. It supports configurable width, stride and reset/clear value, up/down direction, synchronous load and clear, count enable, and wrap or saturate overflow handling with a registered overflow pulse. It sits wherever the design needs odd/even/strided sequences, such as address generators, interleaved channel indices and timeslot counters. It is a single-clock-domain leaf block.

---
 rtl/step_counter_pkg.sv | 13 +
 rtl/step_adder.sv | 26 ++
 rtl/step_counter.sv | 72 +++++++
 tb/tb_step_counter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/step_counter_pkg.sv
// step_counter_pkg: shared types, direction codes and parameter checks for step_counter
package step_counter_pkg;

    typedef enum logic {OVF_WRAP = 1'b0, OVF_SAT = 1'b1} ovf_mode_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic bit is_valid_step(input int width, input longint step);
        return (step >= 1) && (step < (longint'(1) << width));
    endfunction

endpackage

// File: rtl/step_adder.sv
// step_adder: (WIDTH+1)-bit add or subtract of a constant stride with carry/borrow out
module step_adder
    import step_counter_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 2
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic             dir_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_borrow_o
);

    localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

    logic [WIDTH:0] s;

    // Extra top bit is the carry going up and the borrow going down
    always_comb begin
        s = (dir_i == DIR_UP) ? {1'b0, a_i} + STEP_X : {1'b0, a_i} - STEP_X;
    end

    assign sum_o          = s[WIDTH-1:0];
    assign carry_borrow_o = s[WIDTH];

endmodule

// File: rtl/step_counter.sv
// step_counter: strided up/down counter with load, clear, and wrap or saturate on overflow
module step_counter
    import step_counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int STEP     = 2,
    parameter int INIT     = 1,
    parameter int SAT_MODE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             ovf_o
);

    localparam ovf_mode_t        MODE   = ovf_mode_t'(SAT_MODE != 0);
    localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);

    if (WIDTH < 2) begin : g_bad_width
        $error("step_counter: WIDTH must be at least 2");
    end
    if (!is_valid_step(WIDTH, STEP)) begin : g_bad_step
        $error("step_counter: STEP must satisfy 1 <= STEP < 2**WIDTH");
    end
    if (INIT < 0 || longint'(INIT) >= (longint'(1) << WIDTH)) begin : g_bad_init
        $error("step_counter: INIT must be below 2**WIDTH");
    end

    logic [WIDTH-1:0] cnt_q, cnt_d, sum;
    logic             ovf_q, ovf_d, cb;

    step_adder #(.WIDTH(WIDTH), .STEP(STEP)) u_adder (
        .a_i           (cnt_q),
        .dir_i         (dir_i),
        .sum_o         (sum),
        .carry_borrow_o(cb)
    );

    // Priority clear > load > step > hold; saturation keeps the old count on a boundary step
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = 1'b0;
        if (clear_i) begin
            cnt_d = INIT_V;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i) begin
            ovf_d = cb;
            cnt_d = (cb && MODE == OVF_SAT) ? cnt_q : sum;
        end
    end

    // Count and overflow pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= INIT_V;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: tb/tb_step_counter.sv
// tb_step_counter: randomized and directed scoreboard bench for three step_counter configurations
module tb_step_counter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en_i = 1'b0, dir_i = 1'b0, clear_i = 1'b0, load_i = 1'b0;
    logic [7:0] load_val_i = 8'd0;

    logic [7:0] cnt0, cnt1;
    logic [3:0] cnt2;
    logic       ovf0, ovf1, ovf2;

    int n_chk = 0;
    int n_fail = 0;

    // Configurations: 0 = defaults wrap, 1 = defaults saturate, 2 = W4/S3/I0 wrap
    int W[3]   = '{8, 8, 4};
    int S[3]   = '{2, 2, 3};
    int I[3]   = '{1, 1, 0};
    int SAT[3] = '{0, 1, 0};
    int mc[3];

    int q0[$];
    int q1[$];
    int q2[$];

    always #5 clk = ~clk;

    step_counter u_d0 (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .dir_i(dir_i), .clear_i(clear_i),
        .load_i(load_i), .load_val_i(load_val_i), .cnt_o(cnt0), .ovf_o(ovf0)
    );

    step_counter #(.WIDTH(8), .STEP(2), .INIT(1), .SAT_MODE(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .dir_i(dir_i), .clear_i(clear_i),
        .load_i(load_i), .load_val_i(load_val_i), .cnt_o(cnt1), .ovf_o(ovf1)
    );

    step_counter #(.WIDTH(4), .STEP(3), .INIT(0), .SAT_MODE(0)) u_d2 (
        .clk(clk), .rst_n(rst_n), .en_i(en_i), .dir_i(dir_i), .clear_i(clear_i),
        .load_i(load_i), .load_val_i(load_val_i[3:0]), .cnt_o(cnt2), .ovf_o(ovf2)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: integer arithmetic on the counting rules, returns cnt*2+ovf
    function automatic int model_next(input int k, input logic c, input logic l,
                                      input logic [7:0] v, input logic e, input logic d);
        int m;
        int n;
        int ov;
        m = 1 << W[k];
        ov = 0;
        if (c) mc[k] = I[k];
        else if (l) mc[k] = int'(v) % m;
        else if (e) begin
            n = d ? mc[k] + S[k] : mc[k] - S[k];
            if (n < 0 || n >= m) begin
                ov = 1;
                if (SAT[k] == 0) mc[k] = (n + m) % m;
            end else begin
                mc[k] = n;
            end
        end
        return mc[k] * 2 + ov;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) mc[k] = I[k];
    endtask

    // Drive one cycle of stimulus, queue expected results, return just after the edge
    task automatic step(input logic c, input logic l, input logic [7:0] v,
                        input logic e, input logic d);
        @(negedge clk);
        clear_i = c; load_i = l; load_val_i = v; en_i = e; dir_i = d;
        q0.push_back(model_next(0, c, l, v, e, d));
        q1.push_back(model_next(1, c, l, v, e, d));
        q2.push_back(model_next(2, c, l, v, e, d));
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clear_i = 1'b0; load_i = 1'b0; en_i = 1'b0; dir_i = 1'b0; load_val_i = 8'd0;
    endtask

    // Monitor: pops one expectation per DUT per cycle; during reset checks reset values
    always @(posedge clk) begin
        int e;
        #1;
        if (!rst_n) begin
            chk("rst_cnt0", int'(cnt0), 1); chk("rst_ovf0", int'(ovf0), 0);
            chk("rst_cnt1", int'(cnt1), 1); chk("rst_ovf1", int'(ovf1), 0);
            chk("rst_cnt2", int'(cnt2), 0); chk("rst_ovf2", int'(ovf2), 0);
        end else begin
            if (q0.size() > 0) begin
                e = q0.pop_front();
                chk("sb_cnt0", int'(cnt0), e / 2); chk("sb_ovf0", int'(ovf0), e % 2);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("sb_cnt1", int'(cnt1), e / 2); chk("sb_ovf1", int'(ovf1), e % 2);
            end
            if (q2.size() > 0) begin
                e = q2.pop_front();
                chk("sb_cnt2", int'(cnt2), e / 2); chk("sb_ovf2", int'(ovf2), e % 2);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int up3[3] = '{3, 5, 7};
        int sw[6] = '{3, 6, 9, 12, 15, 2};
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic up count from INIT
        chk("post_rst_cnt0", int'(cnt0), 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 1);
            chk("up_cnt0", int'(cnt0), up3[i]);
            chk("up_ovf0", int'(ovf0), 0);
        end

        // Random enabled steps without load: parity of an odd sequence is preserved
        for (int i = 0; i < 300; i++) begin
            step(0, 0, 0, 1, 1'($urandom_range(0, 1)));
            chk("odd_cnt0", int'(cnt0[0]), 1);
            chk("odd_cnt1", int'(cnt1[0]), 1);
        end

        // Wrap up past 255 and back down past 0
        step(0, 1, 8'd255, 0, 0);
        step(0, 0, 0, 1, 1);
        chk("wrap_up_cnt0", int'(cnt0), 1);
        chk("wrap_up_ovf0", int'(ovf0), 1);
        step(0, 0, 0, 0, 0);
        chk("wrap_pulse_end", int'(ovf0), 0);
        step(0, 0, 0, 1, 0);
        chk("wrap_dn_cnt0", int'(cnt0), 255);
        chk("wrap_dn_ovf0", int'(ovf0), 1);

        // Saturation at the top boundary
        step(0, 1, 8'd251, 0, 0);
        step(0, 0, 0, 1, 1);
        chk("sat_cnt1_a", int'(cnt1), 253); chk("sat_ovf1_a", int'(ovf1), 0);
        step(0, 0, 0, 1, 1);
        chk("sat_cnt1_b", int'(cnt1), 255); chk("sat_ovf1_b", int'(ovf1), 0);
        step(0, 0, 0, 1, 1);
        chk("sat_cnt1_c", int'(cnt1), 255); chk("sat_ovf1_c", int'(ovf1), 1);
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 1, 1);
            chk("sat_hold_cnt1", int'(cnt1), 255); chk("sat_hold_ovf1", int'(ovf1), 1);
        end
        step(0, 0, 0, 1, 0);
        chk("sat_dn_cnt1", int'(cnt1), 253); chk("sat_dn_ovf1", int'(ovf1), 0);

        // Priority clear > load > enable
        step(1, 1, 8'h40, 1, 1);
        chk("prio_clear_cnt0", int'(cnt0), 1);
        step(0, 1, 8'h40, 1, 1);
        chk("prio_load_cnt0", int'(cnt0), 8'h40);

        // Random mix including loads and clears
        for (int i = 0; i < 250; i++) begin
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0),
                 8'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in mid-cycle
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 1);
        chk("pre_rst_cnt0", int'(cnt0), 9);
        @(negedge clk);
        idle_inputs();
        en_i = 1'b1; dir_i = 1'b1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_cnt0", int'(cnt0), 1);
        chk("async_ovf0", int'(ovf0), 0);
        chk("async_cnt2", int'(cnt2), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;

        // Narrow counter sweep: wraps from 15 to 2
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 1, 1);
            chk("sweep_cnt2", int'(cnt2), sw[i]);
            chk("sweep_ovf2", int'(ovf2), (i == 5) ? 1 : 0);
        end

        step(0, 0, 0, 0, 0);
        @(negedge clk);
        idle_inputs();
        repeat (2) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
